// File: rtl/sdram_pkg.sv
// sdram_pkg: shared request type, port FSM states and byte-merge helper for the ch1 client port
package sdram_pkg;
    typedef struct packed {
        logic        rnw;
        logic [25:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
    } ch1_req_t;
    typedef enum logic [1:0] {IDLE, WAIT, HIT} state_t;
    function automatic logic [63:0] merge64(input logic [63:0] old_d, input logic [63:0] new_d, input logic [7:0] be);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/sdram_req_fifo.sv
// sdram_req_fifo: synchronous request FIFO; push/din in, pop/dout out (show-ahead head), full/empty flags
module sdram_req_fifo #(
    parameter int WIDTH = 99,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic wr, rd;
    assign wr = push && (!full || pop);
    assign rd = pop && !empty;
    assign empty = wptr == rptr;
    // pointers carry one extra wrap bit so full and empty differ only in that bit
    assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
    assign dout = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sdram_ch1_port.sv
// sdram_ch1_port: client port for SDRAM channel 1 with request FIFO, single-line read cache and timeout flag
// req_* client handshake in, rsp_* responses out, ch1_* controller side, err_timeout sticky error
module sdram_ch1_port import sdram_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023,
    parameter int CACHE_EN   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [25:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_be,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic [25:0] ch1_addr,
    output logic [63:0] ch1_din,
    output logic [7:0]  ch1_be,
    output logic        ch1_rnw,
    output logic        ch1_req,
    input  logic [63:0] ch1_dout,
    input  logic        ch1_ready,
    output logic        err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    ch1_req_t in_req, head;
    state_t state, nxt;
    logic full, empty, pop, hit, go, done;
    logic cache_valid;
    logic [25:0] cache_addr;
    logic [63:0] cache_data;
    logic [CW-1:0] cnt;
    assign in_req = {req_rnw, req_addr, req_wdata, req_be};
    assign req_ready = !full;
    sdram_req_fifo #(.WIDTH($bits(ch1_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(req_valid && req_ready), .din(in_req),
        .pop(pop), .dout(head), .full(full), .empty(empty)
    );
    always_comb begin
        nxt = state;
        pop = 1'b0;
        go = 1'b0;
        done = 1'b0;
        hit = CACHE_EN != 0 && cache_valid && head.rnw && head.addr == cache_addr;
        case (state)
            IDLE: if (!empty) begin
                pop = 1'b1;
                go = !hit;
                nxt = hit ? HIT : WAIT;
            end
            WAIT: if (ch1_ready) begin
                done = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= nxt;
    end
    // ch1_* double as the hold registers: loaded only when a request is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch1_req <= 1'b0;
            ch1_addr <= '0;
            ch1_din <= '0;
            ch1_be <= '0;
            ch1_rnw <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err_timeout <= 1'b0;
            cnt <= '0;
            cache_valid <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
        end else begin
            ch1_req <= go;
            rsp_valid <= done || state == HIT;
            if (go) begin
                ch1_addr <= head.addr;
                ch1_din <= head.wdata;
                ch1_be <= head.be;
                ch1_rnw <= head.rnw;
                cnt <= '0;
            end else if (state == WAIT && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
            // no re-issue on timeout: the controller holds the request until it completes
            if (state == WAIT && !ch1_ready && cnt == CW'(TIMEOUT - 1)) err_timeout <= 1'b1;
            if (state == HIT) rsp_rdata <= cache_data;
            if (done && ch1_rnw) begin
                rsp_rdata <= ch1_dout;
                cache_valid <= CACHE_EN != 0;
                cache_addr <= ch1_addr;
                cache_data <= ch1_dout;
            end
            if (done && !ch1_rnw && cache_valid && ch1_addr == cache_addr)
                cache_data <= merge64(cache_data, ch1_din, ch1_be);
        end
    end
endmodule

// File: tb/tb_sdram_ch1_port.sv
// tb_sdram_ch1_port: directed self-checking bench with a latency-programmable controller model
module tb_sdram_ch1_port;
    localparam int TO = 40;
    logic clk, reset, req_valid, req_ready, req_rnw, rsp_valid, ch1_rnw, ch1_req, ch1_ready, err_timeout;
    logic [25:0] req_addr, ch1_addr;
    logic [63:0] req_wdata, rsp_rdata, ch1_din, ch1_dout;
    logic [7:0] req_be, ch1_be;
    sdram_ch1_port #(.FIFO_DEPTH(4), .TIMEOUT(TO), .CACHE_EN(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .ch1_addr(ch1_addr), .ch1_din(ch1_din), .ch1_be(ch1_be),
        .ch1_rnw(ch1_rnw), .ch1_req(ch1_req), .ch1_dout(ch1_dout), .ch1_ready(ch1_ready),
        .err_timeout(err_timeout)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    logic [63:0] mem [logic [25:0]];
    logic [63:0] rsp_q [$];
    int lat = 4, npulses = 0, req_cyc = 0, rdy_cyc = 0, mcnt = 0;
    bit never = 0, pending = 0;
    initial begin
        logic [63:0] o;
        ch1_ready = 1'b0;
        ch1_dout = '0;
        forever begin
            @(negedge clk);
            ch1_ready = 1'b0;
            if (reset) pending = 0;
            else begin
                if (pending && !never) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        pending = 0;
                        rdy_cyc = cyc;
                        ch1_ready = 1'b1;
                        o = mem.exists(ch1_addr) ? mem[ch1_addr] : 64'h0;
                        if (ch1_rnw) ch1_dout = o;
                        else begin
                            for (int b = 0; b < 8; b++) if (ch1_be[b]) o[8*b +: 8] = ch1_din[8*b +: 8];
                            mem[ch1_addr] = o;
                        end
                    end
                end
                if (ch1_req) begin
                    npulses++;
                    req_cyc = cyc;
                    pending = 1;
                    mcnt = lat;
                end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (rsp_valid) rsp_q.push_back(rsp_rdata);
    end
    task automatic send(input logic rnw, input logic [25:0] a, input logic [63:0] d, input logic [7:0] be);
        int k = 0;
        req_rnw = rnw;
        req_addr = a;
        req_wdata = d;
        req_be = be;
        req_valid = 1'b1;
        while (!req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("accept", 64'(req_ready), 64'h1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("rsp_seen", 64'(rsp_valid), 64'h1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int k, p;
        reset = 1'b1;
        req_valid = 1'b0;
        req_rnw = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_be = '0;
        mem[26'h100] = 64'h1122334455667788;
        for (int i = 0; i < 6; i++) mem[26'h300 + 26'(8*i)] = 64'hC0DE_0000_0000_0000 | 64'(i);
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'h1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_ch1_req", 64'(ch1_req), 64'h0);
        check("rst_err", 64'(err_timeout), 64'h0);
        check("rst_addr", 64'(ch1_addr), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        lat = 8;
        p = npulses;
        send(1'b1, 26'h100, 64'h0, 8'h00);
        wait_rsp(k);
        check("rd1_data", rsp_rdata, 64'h1122334455667788);
        check("rd1_pulses", 64'(npulses - p), 64'h1);
        check("rd1_ready_gap", 64'(rdy_cyc - req_cyc), 64'd8);
        check("rd1_rsp_gap", 64'(cyc - rdy_cyc), 64'd1);
        check("rd1_lat", 64'(k), 64'd10);
        check("rd1_addr", 64'(ch1_addr), 64'h100);
        @(negedge clk);
        p = npulses;
        send(1'b1, 26'h100, 64'h0, 8'h00);
        wait_rsp(k);
        check("hit_lat", 64'(k), 64'd2);
        check("hit_data", rsp_rdata, 64'h1122334455667788);
        check("hit_pulses", 64'(npulses - p), 64'h0);
        @(negedge clk);
        lat = 3;
        p = npulses;
        send(1'b0, 26'h100, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        wait_rsp(k);
        check("wr_be", 64'(ch1_be), 64'h0F);
        check("wr_rnw", 64'(ch1_rnw), 64'h0);
        check("wr_rdata_keep", rsp_rdata, 64'h1122334455667788);
        check("wr_pulses", 64'(npulses - p), 64'h1);
        @(negedge clk);
        send(1'b1, 26'h100, 64'h0, 8'h00);
        wait_rsp(k);
        check("merge_lat", 64'(k), 64'd2);
        check("merge_data", rsp_rdata, 64'h11223344_CCCCDDDD);
        @(negedge clk);
        send(1'b0, 26'h100, 64'h0123_4567_89AB_CDEF, 8'hFF);
        wait_rsp(k);
        @(negedge clk);
        send(1'b0, 26'h200, 64'h5555_5555_5555_5555, 8'hFF);
        wait_rsp(k);
        @(negedge clk);
        p = npulses;
        send(1'b1, 26'h100, 64'h0, 8'h00);
        wait_rsp(k);
        check("full_wr_data", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        check("full_wr_hit", 64'(npulses - p), 64'h0);
        @(negedge clk);
        lat = 30;
        rsp_q.delete();
        p = npulses;
        for (int i = 0; i < 5; i++) send(1'b1, 26'h300 + 26'(8*i), 64'h0, 8'h00);
        check("burst_full", 64'(req_ready), 64'h0);
        send(1'b1, 26'h328, 64'h0, 8'h00);
        k = 0;
        while (rsp_q.size() < 6 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("burst_count", 64'(rsp_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < rsp_q.size(); i++)
            check($sformatf("burst_order%0d", i), rsp_q[i], 64'hC0DE_0000_0000_0000 | 64'(i));
        check("burst_pulses", 64'(npulses - p), 64'd6);
        @(negedge clk);
        never = 1;
        rsp_q.delete();
        p = npulses;
        send(1'b1, 26'h400, 64'h0, 8'h00);
        k = 0;
        while (!err_timeout && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("to_seen", 64'(err_timeout), 64'h1);
        check("to_lat", 64'(cyc - req_cyc), 64'(TO));
        repeat (10) @(negedge clk);
        check("to_pulses", 64'(npulses - p), 64'h1);
        check("to_addr", 64'(ch1_addr), 64'h400);
        check("to_sticky", 64'(err_timeout), 64'h1);
        check("to_no_rsp", 64'(rsp_q.size()), 64'h0);
        #2 reset = 1'b1;
        #1;
        check("arst_err", 64'(err_timeout), 64'h0);
        check("arst_addr", 64'(ch1_addr), 64'h0);
        check("arst_ready", 64'(req_ready), 64'h1);
        check("arst_rnw", 64'(ch1_rnw), 64'h0);
        check("arst_rdata", rsp_rdata, 64'h0);
        repeat (2) @(negedge clk);
        never = 0;
        lat = 4;
        reset = 1'b0;
        @(negedge clk);
        p = npulses;
        send(1'b1, 26'h100, 64'h0, 8'h00);
        wait_rsp(k);
        check("post_miss_pulses", 64'(npulses - p), 64'h1);
        check("post_miss_lat", 64'(k), 64'd6);
        check("post_miss_data", rsp_rdata, 64'h0123_4567_89AB_CDEF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
